// File: rtl/reg_bank_scoreboard.sv
// reg_bank_scoreboard
// Register bank with two combinational read ports, one clocked write-back
// port, optional write-to-read forwarding and a per-register pending bit.
// The pending bits let decode stall on read-after-write hazards. A register
// is reserved when an instruction that targets it issues. It is released
// when that register is written back.
//
// Flag semantics: W_flag and RSV_flag are single-cycle qualifiers with no
// backpressure. Every cycle in which a flag is high is one complete
// transaction, committed at that rising CLK edge. The bank can always accept
// a transaction, so there is no ready signal. Indices >= NB_REG are
// ignored: writes and reservations have no effect, and reads return 0 / not
// busy.
module reg_bank_scoreboard #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int NB_REG = 16,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] A_no,
    input  logic [ADDR_W-1:0] B_no,
    input  logic [ADDR_W-1:0] W_no,
    input  logic [DATA_W-1:0] Data,
    input  logic              W_flag,
    input  logic [ADDR_W-1:0] RSV_no,
    input  logic              RSV_flag,
    output logic [DATA_W-1:0] AS,
    output logic [DATA_W-1:0] BS,
    output logic              A_busy,
    output logic              B_busy,
    output logic              RSV_err,
    output logic [ADDR_W:0]   PEND_cnt
);

    // Storage and scoreboard state
    logic [DATA_W-1:0] regs [NB_REG];
    logic [NB_REG-1:0] pend;
    logic [NB_REG-1:0] pend_next;
    logic [ADDR_W:0]   cnt_next;
    logic              rsv_clash;

    // One-hot decodes. An out-of-range index matches no slot, so every
    // validity rule falls out of these vectors being all-zero.
    logic [NB_REG-1:0] w_sel;
    logic [NB_REG-1:0] rsv_sel;
    logic [NB_REG-1:0] a_sel;
    logic [NB_REG-1:0] b_sel;

    // Read-port intermediate values before forwarding
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              a_pend;
    logic              b_pend;
    logic              a_byp;
    logic              b_byp;

    // Decode every index into a one-hot slot select gated by its enable
    always_comb begin
        w_sel   = '0;
        rsv_sel = '0;
        a_sel   = '0;
        b_sel   = '0;
        for (int i = 0; i < NB_REG; i++) begin
            w_sel[i]   = W_flag   && (W_no   == ADDR_W'(i));
            rsv_sel[i] = RSV_flag && (RSV_no == ADDR_W'(i));
            a_sel[i]   = (A_no == ADDR_W'(i));
            b_sel[i]   = (B_no == ADDR_W'(i));
        end
    end

    // Next pending vector: a write releases its register and a reservation
    // sets its register. A reservation applied after the write wins, which
    // covers a back-to-back producer targeting the same register.
    always_comb begin
        pend_next = (pend & ~w_sel) | rsv_sel;
        // A clash is a reservation on a register that is still pending and
        // is not being released by a write in this same cycle.
        rsv_clash = |(rsv_sel & pend & ~w_sel);
    end

    // Population count of the next pending vector. The count is one bit
    // wider than the index, so it cannot wrap.
    always_comb begin
        cnt_next = '0;
        for (int i = 0; i < NB_REG; i++) begin
            cnt_next = cnt_next + {{ADDR_W{1'b0}}, pend_next[i]};
        end
    end

    // Read muxes. If no slot is selected, the result stays 0 and not busy.
    always_comb begin
        a_data = '0;
        b_data = '0;
        a_pend = 1'b0;
        b_pend = 1'b0;
        for (int i = 0; i < NB_REG; i++) begin
            if (a_sel[i]) begin
                a_data = regs[i];
                a_pend = pend[i];
            end
            if (b_sel[i]) begin
                b_data = regs[i];
                b_pend = pend[i];
            end
        end
    end

    // Forwarding: a write to the register being read shows its data at
    // once. The write also completes the pending value, so busy drops too.
    always_comb begin
        a_byp  = (BYPASS != 0) && (|(w_sel & a_sel));
        b_byp  = (BYPASS != 0) && (|(w_sel & b_sel));
        AS     = a_byp ? Data : a_data;
        BS     = b_byp ? Data : b_data;
        A_busy = a_byp ? 1'b0 : a_pend;
        B_busy = b_byp ? 1'b0 : b_pend;
    end

    // Commit writes, pending bits, the clash pulse and the pending count
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NB_REG; i++) begin
                regs[i] <= '0;
            end
            pend     <= '0;
            RSV_err  <= 1'b0;
            PEND_cnt <= '0;
        end else begin
            for (int i = 0; i < NB_REG; i++) begin
                if (w_sel[i]) begin
                    regs[i] <= Data;
                end
            end
            pend     <= pend_next;
            RSV_err  <= rsv_clash;
            PEND_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_reg_bank_scoreboard.sv
// Bench for reg_bank_scoreboard. Three instances share one stimulus:
//   u_b1  : BYPASS=1, NB_REG=16 (main table)
//   u_b0  : BYPASS=0, NB_REG=16 (write-cycle visibility)
//   u_n12 : BYPASS=1, NB_REG=12 (out-of-range indices)
module tb_reg_bank_scoreboard;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  A_no, B_no, W_no, RSV_no;
    logic [15:0] Data;
    logic        W_flag, RSV_flag;

    logic [15:0] as_b1, bs_b1, as_b0, bs_b0, as_n12, bs_n12;
    logic        ab_b1, bb_b1, ab_b0, bb_b0, ab_n12, bb_n12;
    logic        err_b1, err_b0, err_n12;
    logic [4:0]  cnt_b1, cnt_b0, cnt_n12;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [3:0]  a_no, b_no, w_no;
        logic [15:0] data;
        logic        w_flag;
        logic [3:0]  rsv_no;
        logic        rsv_flag;
        logic [15:0] exp_as, exp_bs;
        logic        exp_ab, exp_bb, exp_err;
        logic [4:0]  exp_cnt;
    } vec_t;

    vec_t vecs[14];

    reg_bank_scoreboard #(.DATA_W(16), .ADDR_W(4), .NB_REG(16), .BYPASS(1)) u_b1 (
        .CLK(CLK), .RST(RST), .A_no(A_no), .B_no(B_no), .W_no(W_no), .Data(Data),
        .W_flag(W_flag), .RSV_no(RSV_no), .RSV_flag(RSV_flag), .AS(as_b1), .BS(bs_b1),
        .A_busy(ab_b1), .B_busy(bb_b1), .RSV_err(err_b1), .PEND_cnt(cnt_b1));

    reg_bank_scoreboard #(.DATA_W(16), .ADDR_W(4), .NB_REG(16), .BYPASS(0)) u_b0 (
        .CLK(CLK), .RST(RST), .A_no(A_no), .B_no(B_no), .W_no(W_no), .Data(Data),
        .W_flag(W_flag), .RSV_no(RSV_no), .RSV_flag(RSV_flag), .AS(as_b0), .BS(bs_b0),
        .A_busy(ab_b0), .B_busy(bb_b0), .RSV_err(err_b0), .PEND_cnt(cnt_b0));

    reg_bank_scoreboard #(.DATA_W(16), .ADDR_W(4), .NB_REG(12), .BYPASS(1)) u_n12 (
        .CLK(CLK), .RST(RST), .A_no(A_no), .B_no(B_no), .W_no(W_no), .Data(Data),
        .W_flag(W_flag), .RSV_no(RSV_no), .RSV_flag(RSV_flag), .AS(as_n12), .BS(bs_n12),
        .A_busy(ab_n12), .B_busy(bb_n12), .RSV_err(err_n12), .PEND_cnt(cnt_n12));

    // Clock
    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic [3:0] a, input logic [3:0] b, input logic [3:0] w,
                                input logic [15:0] d, input logic wf, input logic [3:0] r,
                                input logic rf, input logic [15:0] eas, input logic [15:0] ebs,
                                input logic eab, input logic ebb, input logic eerr,
                                input logic [4:0] ecnt);
        vec_t v;
        v.a_no = a; v.b_no = b; v.w_no = w; v.data = d; v.w_flag = wf;
        v.rsv_no = r; v.rsv_flag = rf;
        v.exp_as = eas; v.exp_bs = ebs; v.exp_ab = eab; v.exp_bb = ebb;
        v.exp_err = eerr; v.exp_cnt = ecnt;
        return v;
    endfunction

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] w,
                         input logic [15:0] d, input logic wf, input logic [3:0] r,
                         input logic rf);
        A_no = a; B_no = b; W_no = w; Data = d; W_flag = wf; RSV_no = r; RSV_flag = rf;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_q(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: expected queue empty, got 0x%0h", name, act);
        end else begin
            e = exp_q.pop_front();
            check(name, act, e);
        end
    endtask

    initial begin
        // Directed vectors on u_b1, starting from a clean bank
        vecs[0]  = mk(3, 3, 3, 16'h00AB, 1, 0, 0,  16'h00AB, 16'h00AB, 0, 0, 0, 0);
        vecs[1]  = mk(3, 0, 0, 16'h0000, 0, 0, 0,  16'h00AB, 16'h0000, 0, 0, 0, 0);
        vecs[2]  = mk(5, 3, 0, 16'h0000, 0, 5, 1,  16'h0000, 16'h00AB, 0, 0, 0, 1);
        vecs[3]  = mk(5, 5, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0, 1);
        vecs[4]  = mk(5, 3, 5, 16'h1234, 1, 0, 0,  16'h1234, 16'h00AB, 0, 0, 0, 0);
        vecs[5]  = mk(5, 5, 0, 16'h0000, 0, 0, 0,  16'h1234, 16'h1234, 0, 0, 0, 0);
        vecs[6]  = mk(7, 5, 0, 16'h0000, 0, 7, 1,  16'h0000, 16'h1234, 0, 0, 0, 1);
        vecs[7]  = mk(7, 7, 0, 16'h0000, 0, 7, 1,  16'h0000, 16'h0000, 1, 1, 1, 1);
        vecs[8]  = mk(7, 7, 0, 16'h0000, 0, 0, 0,  16'h0000, 16'h0000, 1, 1, 0, 1);
        vecs[9]  = mk(7, 7, 7, 16'h0777, 1, 7, 1,  16'h0777, 16'h0777, 0, 0, 0, 1);
        vecs[10] = mk(7, 2, 0, 16'h0000, 0, 0, 0,  16'h0777, 16'h0000, 1, 0, 0, 1);
        vecs[11] = mk(7, 7, 7, 16'h0007, 1, 0, 0,  16'h0007, 16'h0007, 0, 0, 0, 0);
        vecs[12] = mk(10, 9, 9, 16'hBEEF, 1, 10, 1, 16'h0000, 16'hBEEF, 0, 0, 0, 1);
        vecs[13] = mk(10, 9, 10, 16'h0A0A, 1, 10, 1, 16'h0A0A, 16'hBEEF, 0, 0, 0, 1);

        // Reset
        RST = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        step();
        step();
        RST = 1'b0;
        drive(3, 3, 0, 16'h0, 0, 0, 0);
        #1;
        check("init_as", as_b1, 0);
        check("init_busy", ab_b1, 0);
        check("init_cnt", cnt_b1, 0);
        check("init_err", err_b1, 0);
        step();

        // Random writes with chained reservations, then a one-cycle reset
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'(15 - i), 4'(i), 16'($urandom_range(1, 65535)), 1, 4'((i + 1) % 16), 1);
            step();
        end
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        #1;
        check("pre_rst_cnt", cnt_b1, 1);
        check("pre_rst_busy0", ab_b1, 1);
        RST = 1'b1;
        drive(0, 0, 2, 16'hFFFF, 1, 4, 1);
        step();
        RST = 1'b0;
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        #1;
        check("rst_cnt_b1", cnt_b1, 0);
        check("rst_cnt_b0", cnt_b0, 0);
        check("rst_cnt_n12", cnt_n12, 0);
        check("rst_err_b1", err_b1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'(15 - i), 0, 16'h0, 0, 0, 0);
            #1;
            check($sformatf("rst_as_r%0d", i), as_b1, 0);
            check($sformatf("rst_bs_r%0d", 15 - i), bs_b1, 0);
            check($sformatf("rst_abusy_r%0d", i), ab_b1, 0);
            check($sformatf("rst_bbusy_r%0d", 15 - i), bb_b1, 0);
            check($sformatf("rst_as_b0_r%0d", i), as_b0, 0);
        end
        step();

        // Table: combinational outputs before the edge, registered ones after
        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].a_no, vecs[v].b_no, vecs[v].w_no, vecs[v].data, vecs[v].w_flag,
                  vecs[v].rsv_no, vecs[v].rsv_flag);
            #1;
            check($sformatf("vec%0d_as", v), as_b1, vecs[v].exp_as);
            check($sformatf("vec%0d_bs", v), bs_b1, vecs[v].exp_bs);
            check($sformatf("vec%0d_abusy", v), ab_b1, vecs[v].exp_ab);
            check($sformatf("vec%0d_bbusy", v), bb_b1, vecs[v].exp_bb);
            step();
            check($sformatf("vec%0d_err", v), err_b1, vecs[v].exp_err);
            check($sformatf("vec%0d_cnt", v), cnt_b1, vecs[v].exp_cnt);
        end

        // BYPASS=0: the write is visible only after its edge
        drive(3, 3, 3, 16'h55AA, 1, 0, 0);
        #1;
        check("nobyp_old_as", as_b0, 16'h00AB);
        check("byp_new_as", as_b1, 16'h55AA);
        step();
        drive(3, 3, 0, 16'h0, 0, 0, 0);
        #1;
        check("nobyp_next_as", as_b0, 16'h55AA);
        drive(5, 5, 0, 16'h0, 0, 5, 1);
        step();
        drive(5, 5, 5, 16'h4321, 1, 0, 0);
        #1;
        check("nobyp_wr_busy", ab_b0, 1);
        check("nobyp_wr_as", as_b0, 16'h1234);
        check("byp_wr_busy", ab_b1, 0);
        step();
        drive(5, 5, 0, 16'h0, 0, 0, 0);
        #1;
        check("nobyp_after_as", as_b0, 16'h4321);
        check("nobyp_after_busy", ab_b0, 0);
        check("nobyp_cnt", cnt_b0, 1);

        // NB_REG=12: indices 12..15 do not exist
        drive(14, 13, 14, 16'hDEAD, 1, 13, 1);
        #1;
        check("oor_as", as_n12, 0);
        check("oor_abusy", ab_n12, 0);
        check("oor_bs", bs_n12, 0);
        check("inr_as_b1", as_b1, 16'hDEAD);
        step();
        check("oor_err", err_n12, 0);
        check("oor_cnt", cnt_n12, 1);
        check("inr_cnt_b1", cnt_b1, 2);
        drive(14, 13, 0, 16'h0, 0, 13, 1);
        #1;
        check("oor_as_read", as_n12, 0);
        check("oor_bbusy", bb_n12, 0);
        check("inr_bbusy_b1", bb_b1, 1);
        step();
        check("oor_rerv_err", err_n12, 0);
        check("inr_rerv_err_b1", err_b1, 1);
        drive(0, 0, 0, 16'h0, 0, 12, 1);
        step();
        check("oor12_cnt", cnt_n12, 1);
        check("inr12_cnt_b1", cnt_b1, 3);
        drive(0, 0, 0, 16'h0, 0, 11, 1);
        step();
        check("last_valid_cnt", cnt_n12, 2);
        check("last_valid_cnt_b1", cnt_b1, 4);
        check("last_valid_err", err_n12, 0);

        // Reserve every register, then reset mid-sequence
        RST = 1'b1;
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        step();
        RST = 1'b0;
        for (int i = 0; i < 16; i++) exp_q.push_back(32'(i + 1));
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'(i), 0, 16'h0, 0, 4'(i), 1);
            step();
            check_q($sformatf("fill_cnt_%0d", i), cnt_b1);
            check($sformatf("fill_cnt_n12_%0d", i), cnt_n12, (i + 1 < 12) ? i + 1 : 12);
        end
        check("fill_err", err_b1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'(15 - i), 0, 16'h0, 0, 0, 0);
            #1;
            check($sformatf("full_abusy_r%0d", i), ab_b1, 1);
            check($sformatf("full_bbusy_r%0d", 15 - i), bb_b1, 1);
            check($sformatf("full_abusy_n12_r%0d", i), ab_n12, (i < 12) ? 1 : 0);
        end
        step();
        drive(0, 0, 0, 16'h0, 0, 3, 1);
        step();
        check("full_rerv_err", err_b1, 1);
        check("full_rerv_err_n12", err_n12, 1);
        check("full_rerv_cnt", cnt_b1, 16);
        drive(0, 0, 0, 16'h0, 0, 4, 1);
        check("err_one_cycle_pre", err_b1, 1);
        RST = 1'b1;
        step();
        RST = 1'b0;
        drive(0, 0, 0, 16'h0, 0, 0, 0);
        #1;
        check("mid_rst_cnt", cnt_b1, 0);
        check("mid_rst_cnt_n12", cnt_n12, 0);
        check("mid_rst_err", err_b1, 0);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 4'(15 - i), 0, 16'h0, 0, 0, 0);
            #1;
            check($sformatf("mid_rst_abusy_r%0d", i), ab_b1, 0);
            check($sformatf("mid_rst_bbusy_r%0d", 15 - i), bb_b1, 0);
            check($sformatf("mid_rst_abusy_n12_r%0d", i), ab_n12, 0);
        end

        // Final report
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL exp_q_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
